// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial control unit.
package fact_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_INIT  = 3'd1,
      S_CHECK = 3'd2,
      S_MUL   = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } state_e;

   localparam int CYC_W_DEF = 8;

endpackage

// File: rtl/fact_cyc_cnt.sv
// Saturating cycle counter with synchronous clear; used by fact_cu when
// FACT_CU_CYCLE_CNT_EN is defined.
module fact_cyc_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != {W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/fact_cu.sv
// Moore control unit for the iterative factorial datapath.
// Optional cycle counter output enabled by macro FACT_CU_CYCLE_CNT_EN.
module fact_cu
   import fact_pkg::*;
#(
   parameter int CYC_W = CYC_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic             gt_in,
   input  logic             gt_fact,
   output logic             load_cnt,
   output logic             en,
   output logic             sel_1,
   output logic             load_reg,
   output logic             sel_2,
   output logic             done,
`ifdef FACT_CU_CYCLE_CNT_EN
   output logic             err,
   output logic [CYC_W-1:0] cycles
`else
   output logic             err
`endif
);

   state_e state_q, state_d;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (go) state_d = gt_in ? S_ERR : S_INIT;
         S_INIT:  state_d = S_CHECK;
         S_CHECK: state_d = gt_fact ? S_MUL : S_DONE;
         S_MUL:   state_d = S_CHECK;
         S_DONE:  if (!go) state_d = S_IDLE;
         S_ERR:   if (!go) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Outputs depend on the registered state alone.
   always_comb begin
      load_cnt = 1'b0;
      en       = 1'b0;
      sel_1    = 1'b0;
      load_reg = 1'b0;
      sel_2    = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      unique case (state_q)
         S_INIT: begin
            load_cnt = 1'b1;
            load_reg = 1'b1;
         end
         S_MUL: begin
            load_reg = 1'b1;
            sel_1    = 1'b1;
            en       = 1'b1;
         end
         S_DONE: begin
            sel_2 = 1'b1;
            done  = 1'b1;
         end
         S_ERR:   err = 1'b1;
         default: ;
      endcase
   end

`ifdef FACT_CU_CYCLE_CNT_EN
   logic cnt_clr, cnt_inc;

   // Clear on the edge that enters INIT; count every cycle spent computing.
   assign cnt_clr = (state_q == S_IDLE) && (state_d == S_INIT);
   assign cnt_inc = (state_q == S_INIT) || (state_q == S_CHECK) || (state_q == S_MUL);

   fact_cyc_cnt #(
      .W (CYC_W)
   ) u_cyc_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (cnt_inc),
      .cnt (cycles)
   );
`endif

endmodule

// File: tb/tb_fact_cu.sv
// Self-checking bench: fact_cu paired with a 4-bit factorial datapath.
`timescale 1ns/1ps
module tb_fact_cu;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       go  = 1'b0;
   logic [3:0] n   = 4'd0;
   logic       gt_in, gt_fact;
   logic       load_cnt, en, sel_1, load_reg, sel_2, done, err;
`ifdef FACT_CU_CYCLE_CNT_EN
   logic [7:0] cycles;
`endif

   logic [3:0] dp_cnt, dp_prod, nf;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fact_cu #(.CYC_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .go       (go),
      .gt_in    (gt_in),
      .gt_fact  (gt_fact),
      .load_cnt (load_cnt),
      .en       (en),
      .sel_1    (sel_1),
      .load_reg (load_reg),
      .sel_2    (sel_2),
      .done     (done),
`ifdef FACT_CU_CYCLE_CNT_EN
      .err      (err),
      .cycles   (cycles)
`else
      .err      (err)
`endif
   );

   // Factorial datapath: down-counter, product register, output gate.
   always_ff @(posedge clk) begin
      if (load_cnt)
         dp_cnt <= n;
      else if (en)
         dp_cnt <= dp_cnt - 4'd1;
      if (load_reg)
         dp_prod <= sel_1 ? 4'(dp_prod * dp_cnt) : 4'd1;
   end
   assign gt_in   = (n > 4'd12);
   assign gt_fact = (dp_cnt > 4'd1);
   assign nf      = sel_2 ? dp_prod : 4'd0;

   // Mutually exclusive output pairs.
   always @(negedge clk) begin
      n_cmp++;
      if ((load_cnt && en) || (done && err)) begin
         n_bad++;
         $display("FAIL excl_outputs: load_cnt=%0b en=%0b done=%0b err=%0b, required no pair high",
                  load_cnt, en, done, err);
      end
   end

   function automatic int ref_nf(input int nv);
      int p = 1;
      for (int i = 2; i <= nv; i++) p = p * i;
      return p % 16;
   endfunction

   function automatic int ref_muls(input int nv);
      return (nv > 1) ? nv - 1 : 0;
   endfunction

   function automatic int ref_lat(input int nv);
      return 2 + 2 * ref_muls(nv) + 1;
   endfunction

   function automatic int ref_cycles(input int nv);
      int c = 1 + (ref_muls(nv) + 1) + ref_muls(nv);
      return (c > 255) ? 255 : c;
   endfunction

   function automatic int cyc_val();
`ifdef FACT_CU_CYCLE_CNT_EN
      return int'(cycles);
`else
      return 0;
`endif
   endfunction

   // Starts an operation and counts edges until done/err (bounded).
   task automatic run_op(input int nv, input bit hold, output int lat, output int muls,
                         output int loads, output int nfv, output bit saw_err,
                         output bit tmo, output int cyc);
      n = 4'(nv);
      go = 1'b1;
      lat = 0; muls = 0; loads = 0; nfv = 0; saw_err = 0; tmo = 0; cyc = 0;
      while (1) begin
         @(negedge clk);
         lat++;
         if (!hold) go = 1'b0;
         if (en) muls++;
         if (load_cnt || load_reg) loads++;
         if (done || err) break;
         if (lat >= 80) begin
            tmo = 1;
            break;
         end
      end
      saw_err = err;
      nfv = int'(nf);
      cyc = cyc_val();
   endtask

   task automatic idle(input int k);
      go = 1'b0;
      repeat (k) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      go = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({load_cnt, en, sel_1, load_reg, sel_2, done, err} !== 7'b0 || cyc_val() != 0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b cycles=%0d, required 0000000 cycles=0",
                  {load_cnt, en, sel_1, load_reg, sel_2, done, err}, cyc_val());
      end
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_n5;
      int lat, muls, loads, nfv, cyc;
      bit se, tmo;
      run_op(5, 0, lat, muls, loads, nfv, se, tmo, cyc);
      n_cmp++;
      if (tmo || se || lat != 11 || nfv != 8 || muls != 4) begin
         n_bad++;
         $display("FAIL n5_result: got lat=%0d nf=%0d muls=%0d err=%0b tmo=%0b, required lat=11 nf=8 muls=4",
                  lat, nfv, muls, se, tmo);
      end
`ifdef FACT_CU_CYCLE_CNT_EN
      n_cmp++;
      if (cyc != 10) begin
         n_bad++;
         $display("FAIL n5_cycles: got %0d, required 10", cyc);
      end
`endif
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin
         n_bad++;
         $display("FAIL n5_done_one_cycle: got done=%0b, required 0", done);
      end
      idle(1);
   endtask

   task automatic test_small;
      int lat, muls, loads, nfv, cyc;
      bit se, tmo;
      for (int v = 0; v <= 1; v++) begin
         run_op(v, 0, lat, muls, loads, nfv, se, tmo, cyc);
         n_cmp++;
         if (tmo || se || lat != 3 || muls != 0 || nfv != 1 || (cyc != 2 && cyc_val() != 0)) begin
            n_bad++;
            $display("FAIL small_n%0d: got lat=%0d muls=%0d nf=%0d cyc=%0d, required lat=3 muls=0 nf=1 cyc=2",
                     v, lat, muls, nfv, cyc);
         end
         idle(2);
      end
   endtask

   task automatic test_err;
      int lat, muls, loads, nfv, cyc;
      bit se, tmo;
      run_op(13, 1, lat, muls, loads, nfv, se, tmo, cyc);
      n_cmp++;
      if (tmo || !se || lat != 1 || loads != 0) begin
         n_bad++;
         $display("FAIL err_entry: got lat=%0d err=%0b loads=%0d, required lat=1 err=1 loads=0",
                  lat, se, loads);
      end
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if (err !== 1'b1 || load_cnt || load_reg) begin
            n_bad++;
            $display("FAIL err_hold: got err=%0b load_cnt=%0b load_reg=%0b, required 1 0 0",
                     err, load_cnt, load_reg);
         end
      end
      go = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++;
         $display("FAIL err_release: got err=%0b, required 0", err);
      end
      idle(1);
   endtask

   task automatic test_back_to_back;
      int lat, muls, loads, nfv, cyc;
      bit se, tmo;
      run_op(4, 1, lat, muls, loads, nfv, se, tmo, cyc);
      n_cmp++;
      if (tmo || se || lat != 9 || nfv != 8) begin
         n_bad++;
         $display("FAIL hold_n4: got lat=%0d nf=%0d, required lat=9 nf=8", lat, nfv);
      end
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if (done !== 1'b1 || nf !== 4'd8) begin
            n_bad++;
            $display("FAIL hold_done: got done=%0b nf=%0d, required done=1 nf=8", done, nf);
         end
      end
      go = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || load_cnt !== 1'b0) begin
         n_bad++;
         $display("FAIL hold_release: got done=%0b load_cnt=%0b, required 0 0", done, load_cnt);
      end
      go = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (load_cnt !== 1'b1 || load_reg !== 1'b1 || sel_1 !== 1'b0) begin
         n_bad++;
         $display("FAIL restart_init: got load_cnt=%0b load_reg=%0b sel_1=%0b, required 1 1 0",
                  load_cnt, load_reg, sel_1);
      end
      idle(20);
   endtask

   task automatic test_reset_mid;
      int lat, muls, loads, nfv, cyc, k, mulc;
      bit se, tmo;
      n = 4'd6;
      go = 1'b1;
      mulc = 0;
      for (k = 0; k < 40 && mulc < 3; k++) begin
         @(negedge clk);
         if (en) mulc++;
      end
      n_cmp++;
      if (mulc != 3) begin
         n_bad++;
         $display("FAIL rstmid_reach_mul: got %0d MUL cycles, required 3", mulc);
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({load_cnt, en, sel_1, load_reg, sel_2, done, err} !== 7'b0 || cyc_val() != 0) begin
         n_bad++;
         $display("FAIL rstmid_outputs: got %b cycles=%0d, required 0000000 cycles=0",
                  {load_cnt, en, sel_1, load_reg, sel_2, done, err}, cyc_val());
      end
      rst = 1'b0;
      idle(1);
      run_op(3, 0, lat, muls, loads, nfv, se, tmo, cyc);
      n_cmp++;
      if (tmo || se || lat != 7 || nfv != 6) begin
         n_bad++;
         $display("FAIL rstmid_n3: got lat=%0d nf=%0d, required lat=7 nf=6", lat, nfv);
      end
      idle(2);
   endtask

   task automatic test_random;
      int lat, muls, loads, nfv, cyc, nv;
      bit se, tmo, hold;
      for (int it = 0; it < 12; it++) begin
         nv = int'($urandom_range(0, 15));
         hold = 1'($urandom_range(0, 1));
         run_op(nv, hold, lat, muls, loads, nfv, se, tmo, cyc);
         n_cmp++;
         if (nv > 12) begin
            if (tmo || !se || lat != 1 || loads != 0) begin
               n_bad++;
               $display("FAIL rand_err n=%0d: got lat=%0d err=%0b loads=%0d, required lat=1 err=1 loads=0",
                        nv, lat, se, loads);
            end
         end else begin
            if (tmo || se || lat != ref_lat(nv) || nfv != ref_nf(nv) || muls != ref_muls(nv)
                || (cyc_val() != 0 && cyc != ref_cycles(nv))) begin
               n_bad++;
               $display("FAIL rand_op n=%0d: got lat=%0d nf=%0d muls=%0d cyc=%0d, required lat=%0d nf=%0d muls=%0d cyc=%0d",
                        nv, lat, nfv, muls, cyc, ref_lat(nv), ref_nf(nv), ref_muls(nv), ref_cycles(nv));
            end
         end
         idle(2);
      end
   endtask

   initial begin
      test_reset();
      test_n5();
      test_small();
      test_err();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
